// File: rtl/u3v_leader_gen.sv
// U3V leader generator: emits the 13-word (52-byte) USB3 Vision leader,
// one 32-bit little-endian word per cycle, on each rising edge of the
// leader window flag. All fields come from a snapshot taken at leader start.
// Optional build macro: U3V_LEADER_TIMESTAMP_EN adds a 64-bit free-running
// timestamp counter; without it the timestamp words are zero.
module u3v_leader_gen #(
    parameter int DATA_WD     = 32,
    parameter int LONG_REG_WD = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_leader_flag,
    input  logic                   i_chunk_mode_active,
    input  logic [LONG_REG_WD-1:0] iv_blockid,
    input  logic [31:0]            iv_pixel_format,
    input  logic [31:0]            iv_size_x,
    input  logic [31:0]            iv_size_y,
    input  logic [31:0]            iv_offset_x,
    input  logic [31:0]            iv_offset_y,
    input  logic [15:0]            iv_padding_x,
    output logic                   o_leader_valid,
    output logic [DATA_WD-1:0]     ov_leader_data
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SEND     = 2'd1;
    localparam logic [1:0] WAIT_LOW = 2'd2;

    localparam logic [3:0] LAST_WORD = 4'd12;

    logic [1:0]             state;
    logic [3:0]             word_cnt;
    logic                   flag_d;
    logic                   armed;
    logic                   leader_start;

    logic                   snap_chunk;
    logic [LONG_REG_WD-1:0] snap_blockid;
    logic [31:0]            snap_pixel_format;
    logic [31:0]            snap_size_x;
    logic [31:0]            snap_size_y;
    logic [31:0]            snap_offset_x;
    logic [31:0]            snap_offset_y;
    logic [15:0]            snap_padding_x;
    logic [LONG_REG_WD-1:0] snap_ts;

    logic [DATA_WD-1:0]     word;

    // flag_d alone would accept a flag already high at reset release;
    // armed requires the flag to be seen low once after reset.
    assign leader_start = (state == IDLE) && i_leader_flag && !flag_d && armed;

`ifdef U3V_LEADER_TIMESTAMP_EN
    logic [LONG_REG_WD-1:0] ts_cnt;

    // Free-running timestamp, wraps naturally at all-ones
    always_ff @(posedge clk) begin
        if (!reset_n) ts_cnt <= '0;
        else          ts_cnt <= ts_cnt + LONG_REG_WD'(1);
    end

    // Timestamp snapshot taken at leader start
    always_ff @(posedge clk) begin
        if (!reset_n)          snap_ts <= '0;
        else if (leader_start) snap_ts <= ts_cnt;
    end
`else
    assign snap_ts = '0;
`endif

    // Rising-edge detect on the leader window flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flag_d <= 1'b0;
            armed  <= 1'b0;
        end else begin
            flag_d <= i_leader_flag;
            if (!i_leader_flag) armed <= 1'b1;
        end
    end

    // Leader sequencing: IDLE -> SEND (13 words) -> WAIT_LOW / IDLE
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            word_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    word_cnt <= '0;
                    if (leader_start) state <= SEND;
                end
                SEND: begin
                    if (!i_leader_flag) begin
                        state    <= IDLE;
                        word_cnt <= '0;
                    end else if (word_cnt == LAST_WORD) begin
                        state    <= WAIT_LOW;
                        word_cnt <= '0;
                    end else begin
                        word_cnt <= word_cnt + 4'd1;
                    end
                end
                WAIT_LOW: begin
                    word_cnt <= '0;
                    if (!i_leader_flag) state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    word_cnt <= '0;
                end
            endcase
        end
    end

    // Field snapshot so input changes during SEND do not disturb the packet
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            snap_chunk        <= 1'b0;
            snap_blockid      <= '0;
            snap_pixel_format <= '0;
            snap_size_x       <= '0;
            snap_size_y       <= '0;
            snap_offset_x     <= '0;
            snap_offset_y     <= '0;
            snap_padding_x    <= '0;
        end else if (leader_start) begin
            snap_chunk        <= i_chunk_mode_active;
            snap_blockid      <= iv_blockid;
            snap_pixel_format <= iv_pixel_format;
            snap_size_x       <= iv_size_x;
            snap_size_y       <= iv_size_y;
            snap_offset_x     <= iv_offset_x;
            snap_offset_y     <= iv_offset_y;
            snap_padding_x    <= iv_padding_x;
        end
    end

    // Leader word map indexed by the word counter
    always_comb begin
        word = '0;
        case (word_cnt)
            4'd0:    word = 32'h4C56_3355;
            4'd1:    word = 32'h0034_0000;
            4'd2:    word = snap_blockid[31:0];
            4'd3:    word = snap_blockid[63:32];
            4'd4:    word = snap_chunk ? 32'h4001_0000 : 32'h0001_0000;
            4'd5:    word = snap_ts[31:0];
            4'd6:    word = snap_ts[63:32];
            4'd7:    word = snap_pixel_format;
            4'd8:    word = snap_size_x;
            4'd9:    word = snap_size_y;
            4'd10:   word = snap_offset_x;
            4'd11:   word = snap_offset_y;
            4'd12:   word = {16'h0000, snap_padding_x};
            default: word = '0;
        endcase
    end

    assign o_leader_valid = (state == SEND);
    assign ov_leader_data = o_leader_valid ? word : '0;

endmodule

// File: tb/tb_u3v_leader_gen.sv
// Testbench for u3v_leader_gen: directed scenarios plus randomized flag,
// field and reset activity, checked every cycle against a queue-based model.
module tb_u3v_leader_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_leader_flag;
    logic        i_chunk_mode_active;
    logic [63:0] iv_blockid;
    logic [31:0] iv_pixel_format;
    logic [31:0] iv_size_x;
    logic [31:0] iv_size_y;
    logic [31:0] iv_offset_x;
    logic [31:0] iv_offset_y;
    logic [15:0] iv_padding_x;
    logic        o_leader_valid;
    logic [31:0] ov_leader_data;

    always #5 clk = ~clk;

    u3v_leader_gen #(.DATA_WD(32), .LONG_REG_WD(64)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .i_leader_flag       (i_leader_flag),
        .i_chunk_mode_active (i_chunk_mode_active),
        .iv_blockid          (iv_blockid),
        .iv_pixel_format     (iv_pixel_format),
        .iv_size_x           (iv_size_x),
        .iv_size_y           (iv_size_y),
        .iv_offset_x         (iv_offset_x),
        .iv_offset_y         (iv_offset_y),
        .iv_padding_x        (iv_padding_x),
        .o_leader_valid      (o_leader_valid),
        .ov_leader_data      (ov_leader_data)
    );

    int          checks = 0;
    int          errors = 0;

    // Reference model: words still to be shown (head = word on the bus now)
    logic [31:0] q[$];
    bit          prev_flag = 1'b0;
    bit          low_seen  = 1'b0;
    logic [63:0] ts_model  = '0;
    logic [31:0] got[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic build_packet();
        logic [63:0] ts;
`ifdef U3V_LEADER_TIMESTAMP_EN
        ts = ts_model;
`else
        ts = '0;
`endif
        q.delete();
        q.push_back(32'h4C563355);
        q.push_back(32'h00340000);
        q.push_back(iv_blockid[31:0]);
        q.push_back(iv_blockid[63:32]);
        q.push_back(i_chunk_mode_active ? 32'h40010000 : 32'h00010000);
        q.push_back(ts[31:0]);
        q.push_back(ts[63:32]);
        q.push_back(iv_pixel_format);
        q.push_back(iv_size_x);
        q.push_back(iv_size_y);
        q.push_back(iv_offset_x);
        q.push_back(iv_offset_y);
        q.push_back({16'h0000, iv_padding_x});
    endtask

    // Advance the model by one edge, clock the DUT, compare outputs
    task automatic tick();
        logic [31:0] exp_data;
        if (!reset_n) begin
            q.delete();
            prev_flag = 1'b0;
            low_seen  = 1'b0;
            ts_model  = '0;
        end else begin
            if (q.size() > 0) begin
                q.delete(0);
                if (!i_leader_flag) q.delete();
            end else if (i_leader_flag && !prev_flag && low_seen) begin
                build_packet();
            end
            prev_flag = i_leader_flag;
            if (!i_leader_flag) low_seen = 1'b1;
            ts_model = ts_model + 64'd1;
        end
        @(posedge clk);
        #1;
        exp_data = (q.size() > 0) ? q[0] : 32'h0;
        chk("valid", 64'(o_leader_valid), 64'(q.size() > 0));
        chk("data", 64'(ov_leader_data), 64'(exp_data));
        if (o_leader_valid) got.push_back(ov_leader_data);
    endtask

    task automatic rand_fields();
        iv_blockid          = {$urandom(), $urandom()};
        iv_pixel_format     = $urandom();
        iv_size_x           = $urandom();
        iv_size_y           = $urandom();
        iv_offset_x         = $urandom();
        iv_offset_y         = $urandom();
        iv_padding_x        = 16'($urandom());
        i_chunk_mode_active = 1'($urandom_range(0, 1));
    endtask

    initial begin
        logic [63:0] ts1;
        logic [63:0] ts2;

        reset_n = 1'b0;
        i_leader_flag = 1'b0;
        rand_fields();

        // Reset state
        repeat (3) tick();
        chk("rst_valid", 64'(o_leader_valid), 64'd0);
        chk("rst_data", 64'(ov_leader_data), 64'd0);

        // Flag already high at reset release must not start a leader
        i_leader_flag = 1'b1;
        tick();
        reset_n = 1'b1;
        got.delete();
        repeat (4) tick();
        chk("release_no_pkt", 64'(got.size()), 64'd0);
        i_leader_flag = 1'b0;
        repeat (2) tick();

        // Basic packet, flag high 13 cycles
        iv_blockid = 64'h0000000100000002;
        iv_size_x = 32'd1280;
        i_chunk_mode_active = 1'b0;
        got.delete();
        i_leader_flag = 1'b1;
        repeat (13) tick();
        i_leader_flag = 1'b0;
        repeat (3) tick();
        chk("basic_count", 64'(got.size()), 64'd13);
        chk("basic_w0", 64'(got[0]), 64'h4C563355);
        chk("basic_w1", 64'(got[1]), 64'h00340000);
        chk("basic_w2", 64'(got[2]), 64'h00000002);
        chk("basic_w3", 64'(got[3]), 64'h00000001);
        chk("basic_w4", 64'(got[4]), 64'h00010000);
        chk("basic_w8", 64'(got[8]), 64'h00000500);

        // Chunk mode, flag held 30 cycles: one packet only
        i_chunk_mode_active = 1'b1;
        got.delete();
        i_leader_flag = 1'b1;
        repeat (30) tick();
        i_leader_flag = 1'b0;
        repeat (3) tick();
        chk("chunk_count", 64'(got.size()), 64'd13);
        chk("chunk_w4", 64'(got[4]), 64'h40010000);

        // Abort after 5 cycles, re-rise 2 cycles later
        i_chunk_mode_active = 1'b0;
        got.delete();
        i_leader_flag = 1'b1;
        repeat (5) tick();
        i_leader_flag = 1'b0;
        repeat (2) tick();
        chk("abort_count", 64'(got.size()), 64'd5);
        chk("abort_w4", 64'(got[4]), 64'h00010000);
        i_leader_flag = 1'b1;
        repeat (15) tick();
        i_leader_flag = 1'b0;
        repeat (3) tick();
        chk("restart_count", 64'(got.size()), 64'd18);
        chk("restart_w0", 64'(got[5]), 64'h4C563355);
        chk("restart_w3", 64'(got[8]), 64'h00000001);

        // Input change during SEND is ignored
        iv_size_y = 32'd1024;
        iv_padding_x = 16'hABCD;
        got.delete();
        i_leader_flag = 1'b1;
        repeat (3) tick();
        iv_size_y = 32'd7;
        iv_padding_x = 16'h1234;
        repeat (12) tick();
        i_leader_flag = 1'b0;
        repeat (2) tick();
        chk("snap_w9", 64'(got[9]), 64'd1024);
        chk("snap_w12", 64'(got[12]), 64'h0000ABCD);

        // Reset at word 6 with flag held high
        got.delete();
        i_leader_flag = 1'b1;
        repeat (7) tick();
        chk("pre_rst_word", 64'(ov_leader_data), 64'(got[6]));
        reset_n = 1'b0;
        tick();
        chk("rst_abort_valid", 64'(o_leader_valid), 64'd0);
        chk("rst_abort_data", 64'(ov_leader_data), 64'd0);
        reset_n = 1'b1;
        got.delete();
        repeat (5) tick();
        chk("rst_no_retrigger", 64'(got.size()), 64'd0);
        i_leader_flag = 1'b0;
        tick();
        i_leader_flag = 1'b1;
        repeat (14) tick();
        i_leader_flag = 1'b0;
        repeat (2) tick();
        chk("rst_new_pkt", 64'(got.size()), 64'd13);

        // Two leaders whose rises are 100 cycles apart
        got.delete();
        i_leader_flag = 1'b1;
        repeat (15) tick();
        i_leader_flag = 1'b0;
        repeat (85) tick();
        i_leader_flag = 1'b1;
        repeat (14) tick();
        i_leader_flag = 1'b0;
        repeat (2) tick();
        chk("ts_count", 64'(got.size()), 64'd26);
        ts1 = {got[6], got[5]};
        ts2 = {got[19], got[18]};
`ifdef U3V_LEADER_TIMESTAMP_EN
        chk("ts_delta", ts2 - ts1, 64'd100);
`else
        chk("ts_zero_a", ts1, 64'd0);
        chk("ts_zero_b", ts2, 64'd0);
`endif

        // Randomized flag, field and reset activity
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) i_leader_flag = ~i_leader_flag;
            if ($urandom_range(0, 3) == 0) rand_fields();
            reset_n = ($urandom_range(0, 79) != 0);
            tick();
        end
        reset_n = 1'b1;
        i_leader_flag = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/u3v_leader_gen.md
U3V_LEADER_GEN -- requirements
Module: u3v_leader_gen

Interface
REQ-001 Parameter DATA_WD, default 32, sets the output data width; only 32 is supported.
REQ-002 Parameter LONG_REG_WD, default 64, sets the block ID and timestamp width.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset_n  in  1  active-low reset, synchronous to clk; this is the only reset.
REQ-005 i_leader_flag  in  1  leader window from the format-control stage; a 0->1 transition requests one leader.
REQ-006 i_chunk_mode_active  in  1  selects the chunk payload type; sampled at the leader start.
REQ-007 iv_blockid  in  LONG_REG_WD  block ID of the current frame.
REQ-008 iv_pixel_format  in  32  PFNC pixel format code.
REQ-009 iv_size_x, iv_size_y, iv_offset_x, iv_offset_y  in  32 each  image geometry.
REQ-010 iv_padding_x  in  16  horizontal padding in bytes.
REQ-011 o_leader_valid  out  1  leader word valid.
REQ-012 ov_leader_data  out  DATA_WD  leader word, U3V little-endian byte order.

Function
REQ-013 The block SHALL implement three states: IDLE, SEND and WAIT_LOW.
REQ-014 IDLE->SEND SHALL occur on the first cycle i_leader_flag=1 whose previous registered sample was 0.
- On that same edge, all field inputs and the timestamp SHALL be latched into a snapshot.
- The word counter SHALL be set to 0.
REQ-015 In SEND the block SHALL output one word per cycle, words 0..12, with o_leader_valid=1.
- Word 0 SHALL appear on the edge after the rising edge of i_leader_flag is sampled (latency 1 cycle).
REQ-016 The word map SHALL be:
- w0 = 0x4C563355 ("U3VL")
- w1 = 0x00340000 (leader_size 52, reserved 0)
- w2 = blockid[31:0]
- w3 = blockid[63:32]
- w4 = 0x00010000, or 0x40010000 when chunk mode is latched
- w5 = ts[31:0]
- w6 = ts[63:32]
- w7 = pixel_format
- w8 = size_x
- w9 = size_y
- w10 = offset_x
- w11 = offset_y
- w12 = {16'h0000, padding_x}
REQ-017 After w12, the state SHALL go to WAIT_LOW if i_leader_flag=1, else to IDLE; o_leader_valid=0 on the next cycle.
REQ-018 WAIT_LOW SHALL emit nothing and go to IDLE when i_leader_flag=0; a flag held high never retriggers.
REQ-019 If i_leader_flag drops while in SEND, the packet SHALL be aborted.
- o_leader_valid=0 from the next edge, and the state goes to IDLE.
- The truncated packet is not resumed.
REQ-020 A new rising edge following an abort SHALL start a complete fresh packet from w0.
REQ-021 When o_leader_valid=0, ov_leader_data SHALL be 0.
REQ-022 Input changes during SEND SHALL NOT affect the words being emitted; only the snapshot is used.
REQ-023 The word counter SHALL be 4 bits and SHALL never exceed 12.

Reset
REQ-024 With reset_n=0 at an edge, the block SHALL enter IDLE with o_leader_valid=0, ov_leader_data=0, counter=0, snapshot=0 and the edge-detect register=0.
REQ-025 Reset asserted during SEND SHALL abort immediately; after release, a new leader requires a fresh 0->1 transition of i_leader_flag.
REQ-026 The reset release cycle SHALL NOT count as a rising edge if i_leader_flag is already 1, because the edge-detect register is cleared to 0 and then must see the flag low before a rise is accepted.

Configuration
REQ-027 Macro U3V_LEADER_TIMESTAMP_EN defined: a 64-bit free-running counter SHALL be included.
- It is cleared by reset and increments by 1 each clk, wrapping at 2^64-1 -> 0.
- Its value SHALL be latched at the leader start and used as ts.
REQ-028 Macro U3V_LEADER_TIMESTAMP_EN undefined: no timestamp counter SHALL exist, and w5 = w6 = 0.

Verification
REQ-029 Reset release, then i_leader_flag rises and stays high 13 cycles with blockid=0x0000000100000002, size_x=1280, chunk=0.
- Expect exactly 13 valid words starting 1 cycle later: w2=0x00000002, w3=0x00000001, w4=0x00010000, w8=0x00000500.
REQ-030 Same stimulus with chunk=1 and the flag held for 30 cycles.
- Expect w4=0x40010000, valid for exactly 13 cycles, and no second packet.
REQ-031 Flag drops after 5 cycles.
- Expect valid for words w0..w4 only (or fewer per REQ-019 timing), then 0.
- Flag re-rises 2 cycles later: expect a full 13-word packet starting at w0.
REQ-032 Change iv_size_y from 1024 to 7 during SEND.
- Expect w9=1024.
- Expect padding_x=0xABCD to produce w12=0x0000ABCD.
REQ-033 Assert reset_n=0 at word 6 while the flag stays high.
- Expect valid=0 and data=0 on the next edge.
- Expect no packet until the flag goes low then high again.
REQ-034 With U3V_LEADER_TIMESTAMP_EN defined, send two leaders whose flag rises are 100 cycles apart.
- Expect the {w6,w5} difference = 100.
- Without the macro, expect w5 = w6 = 0.
